// File: rtl/lpc_frame_scheduler_if.sv
// Handshake and coefficient-memory bus between the LPC frame scheduler
// and its surroundings (frame buffer, autocorrelation, levinson, host).
interface lpc_frame_scheduler_if;
  logic        frame_valid;
  logic        frame_ack;
  logic        ac_start;
  logic        ac_done;
  logic        lev_reset;
  logic        lev_ready;
  logic [9:0]  lev_rsel;
  logic [9:0]  host_rsel;
  logic [9:0]  mem_rsel;
  logic [31:0] mem_rdata;
  logic [31:0] host_rdata;
  logic        host_grant;
  logic        coef_valid;
  logic        coef_release;
  logic        busy;
  logic [15:0] frame_count;
  logic        err_timeout;

  modport master (
    input  frame_valid, ac_done, lev_ready, lev_rsel, host_rsel, mem_rdata, coef_release,
    output frame_ack, ac_start, lev_reset, mem_rsel, host_rdata, host_grant, coef_valid,
           busy, frame_count, err_timeout
  );

  modport slave (
    output frame_valid, ac_done, lev_ready, lev_rsel, host_rsel, mem_rdata, coef_release,
    input  frame_ack, ac_start, lev_reset, mem_rsel, host_rdata, host_grant, coef_valid,
           busy, frame_count, err_timeout
  );
endinterface

// File: rtl/lpc_frame_scheduler.sv
// Per-frame sequencer for the LPC analysis chain: kicks autocorrelation,
// restarts levinson, holds the coefficients for the host and muxes the
// coefficient memory read port. Waits are bounded by a timeout that
// discards the frame and raises a sticky error.
module lpc_frame_scheduler #(
  parameter int LEV_RST_CYCLES = 2,
  parameter int TIMEOUT        = 4095
) (
  input  logic                  clk,
  input  logic                  reset,
  lpc_frame_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AC_START = 3'd1,
    AC_WAIT  = 3'd2,
    LEV_RST  = 3'd3,
    LEV_WAIT = 3'd4,
    HOLD     = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] rst_cnt;
  logic [15:0] frame_cnt;
  logic        ack_q;
  logic        err_q;
  logic        expired;
  logic        abort;
  logic        inc_frame;
  logic        fire_ack;

  assign expired = (wait_cnt == 16'(TIMEOUT));

  // Next-state decode; completion is tested before expiry so it wins a tie
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    inc_frame = 1'b0;
    fire_ack  = 1'b0;
    case (state)
      IDLE:     if (bus.frame_valid) state_nxt = AC_START;
      AC_START: state_nxt = AC_WAIT;
      AC_WAIT: begin
        if (bus.ac_done) begin
          state_nxt = LEV_RST;
          fire_ack  = 1'b1;
        end else if (expired) begin
          state_nxt = IDLE;
          abort     = 1'b1;
          fire_ack  = 1'b1;
        end
      end
      LEV_RST:  if (rst_cnt == 16'd0) state_nxt = LEV_WAIT;
      LEV_WAIT: begin
        // a ready still high from the previous run is ignored on the first cycle
        if (bus.lev_ready && (wait_cnt != 16'd0)) begin
          state_nxt = HOLD;
          inc_frame = 1'b1;
        end else if (expired) begin
          state_nxt = IDLE;
          abort     = 1'b1;
          fire_ack  = 1'b1;
        end
      end
      HOLD:     if (bus.coef_release) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Wait counter: zero on entry to any state, counts while waiting
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= 16'd0;
    else if (state_nxt != state)
      wait_cnt <= 16'd0;
    else if ((state == AC_WAIT) || (state == LEV_WAIT))
      wait_cnt <= wait_cnt + 16'd1;
  end

  // Levinson reset down-counter, loaded on entry to LEV_RST
  always_ff @(posedge clk) begin
    if (reset)
      rst_cnt <= 16'd0;
    else if ((state != LEV_RST) && (state_nxt == LEV_RST))
      rst_cnt <= 16'(LEV_RST_CYCLES - 1);
    else if ((state == LEV_RST) && (rst_cnt != 16'd0))
      rst_cnt <= rst_cnt - 16'd1;
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)          frame_cnt <= 16'd0;
    else if (inc_frame) frame_cnt <= frame_cnt + 16'd1;
  end

  // Registered frame_ack pulse and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= fire_ack;
      if (abort) err_q <= 1'b1;
    end
  end

  assign bus.ac_start    = (state == AC_START);
  assign bus.frame_ack   = ack_q;
  assign bus.lev_reset   = (state != LEV_WAIT) && (state != HOLD);
  assign bus.host_grant  = (state == IDLE) || (state == HOLD);
  assign bus.coef_valid  = (state == HOLD);
  assign bus.busy        = (state != IDLE);
  assign bus.frame_count = frame_cnt;
  assign bus.err_timeout = err_q;
  assign bus.mem_rsel    = ((state == LEV_RST) || (state == LEV_WAIT)) ? bus.lev_rsel : bus.host_rsel;
  assign bus.host_rdata  = bus.mem_rdata;

endmodule

// File: doc/lpc_frame_scheduler.md
# lpc_frame_scheduler

Per-frame sequencer for the LPC analysis chain. For each buffered speech frame it starts the autocorrelation engine, then restarts and runs the `levinson` recursion by pulsing its reset and waiting for `ready`. It then holds the finished coefficients for the host. It also arbitrates the single read port of the coefficient memory between the `levinson` datapath and the host readout.

## Interface
- `LEV_RST_CYCLES`, default 2: cycles `lev_reset` is held high in `LEV_RST` (≥1).
- `TIMEOUT`, default 4095: maximum wait cycles in `AC_WAIT` or `LEV_WAIT` before abort (1..65535).
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `frame_valid` in 1: a full frame is available (level; sampled only in `IDLE`).
- `frame_ack` out 1: one-cycle pulse; the frame buffer may be refilled.
- `ac_start` out 1: one-cycle start pulse to the autocorrelation engine.
- `ac_done` in 1: autocorrelation complete (pulse; honoured only in `AC_WAIT`).
- `lev_reset` out 1: reset to `levinson`; recursion runs while low.
- `lev_ready` in 1: `levinson` `ready`.
- `lev_rsel` in 10: coefficient read select from `levinson`.
- `host_rsel` in 10: coefficient read select from host.
- `mem_rsel` out 10: read select to coefficient memory.
- `mem_rdata` in 32: coefficient memory read data.
- `host_rdata` out 32: `mem_rdata` passthrough.
- `host_grant` out 1: host owns the memory read port.
- `coef_valid` out 1: coefficients for the current frame are final.
- `coef_release` in 1: host done reading (honoured only in `HOLD`).
- `busy` out 1: state not `IDLE`.
- `frame_count` out 16: frames completed; wraps at 65535→0.
- `err_timeout` out 1: sticky abort flag.

## Operation
- States: `IDLE`, `AC_START`, `AC_WAIT`, `LEV_RST`, `LEV_WAIT`, `HOLD`.
- `IDLE`: go to `AC_START` when `frame_valid` is high.
- `AC_START`: `ac_start`=1 for one cycle, then go to `AC_WAIT`.
- `AC_WAIT`: on `ac_done`, pulse `frame_ack` and go to `LEV_RST`.
- `LEV_RST`: stay for exactly `LEV_RST_CYCLES` cycles (down-counter), then go to `LEV_WAIT`.
- `LEV_WAIT`: `lev_ready` is ignored in the first cycle of the state, which guards against a stale ready. After that, `lev_ready`=1 moves to `HOLD` and increments `frame_count`.
- `HOLD`: `coef_valid`=1. `coef_release` moves to `IDLE`.
- `lev_reset`=1 in `IDLE`, `AC_START`, `AC_WAIT` and `LEV_RST`; 0 in `LEV_WAIT` and `HOLD`.
- `host_grant`=1 in `IDLE` and `HOLD`; 0 otherwise.
- `mem_rsel` = `lev_rsel` in `LEV_RST`/`LEV_WAIT`, otherwise `host_rsel`.
- `host_rdata` = `mem_rdata` always.
- Timeout:
  - A 16-bit wait counter clears on entry to `AC_WAIT` or `LEV_WAIT` and increments each cycle in those states.
  - When it reaches `TIMEOUT` with no completion, the next state is `IDLE`, `err_timeout` sets, and `frame_ack` pulses so the frame is discarded.
  - `frame_count` does not increment on an aborted frame.
- Simultaneous events and ignored inputs:
  - Completion (`ac_done`/`lev_ready`) in the same cycle as expiry: completion wins.
  - `frame_valid` outside `IDLE`, `ac_done` outside `AC_WAIT`, and `coef_release` outside `HOLD` are ignored.
- `err_timeout` clears only on `reset`.
- Reset, including mid-frame:
  - State returns to `IDLE`, counters clear, `frame_count`=0.
  - `lev_reset`=1, `host_grant`=1.
  - All other outputs are 0.
  - No `frame_ack` is generated for the interrupted frame.

## Timing
- Outputs are decoded from registered state and counters. The only combinational input-to-output paths are `mem_rsel` and `host_rdata`.
- `frame_valid`=1 in `IDLE` at cycle 0 → `ac_start`=1 in cycle 1 → `AC_WAIT` from cycle 2.
- `ac_done` at cycle n → `frame_ack`=1 in cycle n+1 only → `lev_reset` high for cycles n+1 .. n+`LEV_RST_CYCLES` → `lev_reset`=0 from n+`LEV_RST_CYCLES`+1.
- `lev_ready` accepted at cycle m → `coef_valid`=1, `host_grant`=1 and new `frame_count` from cycle m+1.
- `coef_release` at cycle p → `coef_valid`=0 at p+1 → earliest next `ac_start` at p+2.
- Timeout: wait entered at cycle t → abort when the counter reaches `TIMEOUT` at cycle t+`TIMEOUT` → `IDLE`, `err_timeout`=1 and `frame_ack`=1 in cycle t+`TIMEOUT`+1.

## Test plan
- Nominal frame (`LEV_RST_CYCLES`=2):
  - `frame_valid`=1, `ac_done` 20 cycles after `ac_start`, `lev_ready` 300 cycles after `lev_reset` falls.
  - Expect one `ac_start`, one `frame_ack`, `lev_reset` high for exactly 2 cycles, and `coef_valid`=1 with `frame_count`=1 one cycle after `lev_ready`.
- Arbitration:
  - `lev_rsel`=0x005, `host_rsel`=0x3FF.
  - In `LEV_WAIT` expect `mem_rsel`=0x005 and `host_grant`=0.
  - In `HOLD` expect `mem_rsel`=0x3FF and `host_grant`=1, with `host_rdata` tracking `mem_rdata`=0xDEADBEEF.
- Stale ready:
  - Hold `lev_ready`=1 continuously.
  - Expect `lev_ready` ignored in `LEV_RST` and the first `LEV_WAIT` cycle; `HOLD` entered in the second `LEV_WAIT` cycle + 1.
- Timeout (`TIMEOUT`=16):
  - Never assert `ac_done`.
  - Expect `IDLE`, `err_timeout`=1 and `frame_ack` pulse 17 cycles after entering `AC_WAIT`; `frame_count` unchanged.
  - Second case: `ac_done` on the expiry cycle → normal path taken, `err_timeout`=0.
- Backpressure/ignored inputs:
  - `coef_release` during `AC_WAIT`: no effect.
  - `frame_valid` held in `HOLD`: no `ac_start` until 2 cycles after `coef_release`.
  - `frame_count` wraps 0xFFFF→0x0000 after preload via 65536 short frames, or via a forced counter in the bench.
- Reset mid-`LEV_WAIT`:
  - Expect `IDLE`, `lev_reset`=1, `coef_valid`=0, `frame_count`=0, `err_timeout`=0 on the next cycle, with no `frame_ack`.
